// File: rtl/b_to_f_ctrl_if.sv
// Handshake and operand bundle between the F(B) sequencer and the frequency calculator.
// The master side is the sequencer; the slave side is the calculator.
interface b_to_f_ctrl_if;
    logic        calc_start;
    logic [31:0] calc_b_field;
    logic [31:0] calc_a;
    logic [31:0] calc_b;
    logic [31:0] calc_c;
    logic [7:0]  calc_k;
    logic        calc_ready;
    logic [31:0] calc_freq;

    modport master (
        output calc_start, calc_b_field, calc_a, calc_b, calc_c, calc_k,
        input  calc_ready, calc_freq
    );

    modport slave (
        input  calc_start, calc_b_field, calc_a, calc_b, calc_c, calc_k,
        output calc_ready, calc_freq
    );
endinterface

// File: rtl/b_to_f_ctrl.sv
// Sequencer for the F(B) calculator: triggers, B snapshot, coefficient shadowing,
// start/ready handshake, result publishing and watchdog supervision.
module b_to_f_ctrl #(
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [31:0] A_DEF    = 32'd937546000,
    parameter logic [31:0] B_DEF    = 32'd867339,
    parameter logic [31:0] C_DEF    = 32'd436224,
    parameter logic [7:0]  K_DEF    = 8'd1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic                manual_req,
    input  logic [31:0]         b_field,
    input  logic [31:0]         coef_a,
    input  logic [31:0]         coef_b,
    input  logic [31:0]         coef_c,
    input  logic [7:0]          coef_k,
    input  logic                coef_wr,
    input  logic                clear_err,
    b_to_f_ctrl_if.master       calc,
    output logic [31:0]         freq,
    output logic                freq_valid,
    output logic                busy,
    output logic                timeout_err,
    output logic [15:0]         overrun_cnt
);

    localparam int unsigned WdW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StDone} state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [7:0]  k;
    } coef_t;

    localparam coef_t CoefDef = '{a: A_DEF, b: B_DEF, c: C_DEF, k: K_DEF};

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                tick_pend_q, tick_pend_d;
    logic                man_pend_q, man_pend_d;
    logic                coef_pend_q, coef_pend_d;
    coef_t               shadow_q, shadow_d;
    coef_t               active_q, active_d;
    logic [31:0]         b_lat_q, b_lat_d;
    logic                calc_start_q, calc_start_d;
    logic [WdW-1:0]      wd_q, wd_d;
    logic                ready_q, ready_d;
    logic [31:0]         freq_q, freq_d;
    logic                freq_valid_q, freq_valid_d;
    logic                err_q, err_d;
    logic [15:0]         overrun_q, overrun_d;

    logic tick, launch, apply, timeout;

    always_comb begin
        state_d      = state_q;
        b_lat_d      = b_lat_q;
        calc_start_d = 1'b0;
        wd_d         = wd_q;
        freq_d       = freq_q;
        freq_valid_d = 1'b0;
        launch       = 1'b0;
        apply        = 1'b0;
        timeout      = 1'b0;

        tick  = enable && (cnt_q == period);
        cnt_d = (!enable || tick) ? '0 : cnt_q + PERIOD_W'(1);

        case (state_q)
            StIdle: begin
                // A pending coefficient load takes the cycle; any launch waits one more.
                if (coef_pend_q) begin
                    apply = 1'b1;
                end else if (tick_pend_q || man_pend_q) begin
                    launch       = 1'b1;
                    b_lat_d      = b_field;
                    calc_start_d = 1'b1;
                    state_d      = StLaunch;
                end
            end
            StLaunch: begin
                wd_d    = '0;
                state_d = StWait;
            end
            StWait: begin
                if (calc.calc_ready && !ready_q) begin
                    freq_d       = calc.calc_freq;
                    freq_valid_d = 1'b1;
                    state_d      = StDone;
                end else if (wd_q == WdW'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = StIdle;
                end else begin
                    wd_d = wd_q + WdW'(1);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // New requests win over the clear issued by a launch in the same cycle.
        tick_pend_d = tick | (tick_pend_q & ~launch);
        man_pend_d  = manual_req | (man_pend_q & ~launch);
        overrun_d   = (tick && tick_pend_q && overrun_q != 16'hFFFF) ? overrun_q + 16'd1
                                                                      : overrun_q;

        shadow_d    = coef_wr ? coef_t'{a: coef_a, b: coef_b, c: coef_c, k: coef_k} : shadow_q;
        coef_pend_d = coef_wr | (coef_pend_q & ~apply);
        active_d    = apply ? shadow_q : active_q;

        err_d   = timeout | (err_q & ~clear_err);
        ready_d = calc.calc_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            tick_pend_q  <= 1'b0;
            man_pend_q   <= 1'b0;
            coef_pend_q  <= 1'b0;
            shadow_q     <= CoefDef;
            active_q     <= CoefDef;
            b_lat_q      <= '0;
            calc_start_q <= 1'b0;
            wd_q         <= '0;
            ready_q      <= 1'b0;
            freq_q       <= '0;
            freq_valid_q <= 1'b0;
            err_q        <= 1'b0;
            overrun_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tick_pend_q  <= tick_pend_d;
            man_pend_q   <= man_pend_d;
            coef_pend_q  <= coef_pend_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            b_lat_q      <= b_lat_d;
            calc_start_q <= calc_start_d;
            wd_q         <= wd_d;
            ready_q      <= ready_d;
            freq_q       <= freq_d;
            freq_valid_q <= freq_valid_d;
            err_q        <= err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign calc.calc_start   = calc_start_q;
    assign calc.calc_b_field = b_lat_q;
    assign calc.calc_a       = active_q.a;
    assign calc.calc_b       = active_q.b;
    assign calc.calc_c       = active_q.c;
    assign calc.calc_k       = active_q.k;

    assign freq        = freq_q;
    assign freq_valid  = freq_valid_q;
    assign busy        = (state_q != StIdle);
    assign timeout_err = err_q;
    assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_b_to_f_ctrl.sv
// Directed bench for b_to_f_ctrl with a mock calculator that raises ready a fixed
// number of cycles after each start (or never, when the delay is 0).
module tb_b_to_f_ctrl;
    localparam logic [31:0] A_DEF = 32'd937546000;
    localparam logic [31:0] B_DEF = 32'd867339;
    localparam logic [31:0] C_DEF = 32'd436224;
    localparam logic [7:0]  K_DEF = 8'd1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] period = 16'd0;
    logic        manual_req = 1'b0;
    logic [31:0] b_field = 32'd0;
    logic [31:0] coef_a = A_DEF, coef_b = B_DEF, coef_c = C_DEF;
    logic [7:0]  coef_k = K_DEF;
    logic        coef_wr = 1'b0;
    logic        clear_err = 1'b0;
    logic [31:0] freq;
    logic        freq_valid, busy, timeout_err;
    logic [15:0] overrun_cnt;

    int checks = 0;
    int errors = 0;

    int          mock_delay = 10;
    int          mock_cnt = 0;
    logic        mock_ready = 1'b0;
    logic [31:0] mock_freq = 32'h12345678;

    b_to_f_ctrl_if ifc ();

    assign ifc.calc_ready = mock_ready;
    assign ifc.calc_freq  = mock_freq;

    b_to_f_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .period      (period),
        .manual_req  (manual_req),
        .b_field     (b_field),
        .coef_a      (coef_a),
        .coef_b      (coef_b),
        .coef_c      (coef_c),
        .coef_k      (coef_k),
        .coef_wr     (coef_wr),
        .clear_err   (clear_err),
        .calc        (ifc),
        .freq        (freq),
        .freq_valid  (freq_valid),
        .busy        (busy),
        .timeout_err (timeout_err),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    // Mock calculator: ready drops on start and rises mock_delay cycles later.
    always @(negedge clk) begin
        if (ifc.calc_start) begin
            mock_ready = 1'b0;
            mock_cnt   = mock_delay;
        end else if (mock_cnt > 0) begin
            mock_cnt = mock_cnt - 1;
            if (mock_cnt == 0) mock_ready = 1'b1;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            checks++;
            if (ifc.calc_start !== 1'b0 || ifc.calc_b_field !== 32'd0 || ifc.calc_a !== A_DEF ||
                ifc.calc_b !== B_DEF || ifc.calc_c !== C_DEF || ifc.calc_k !== K_DEF ||
                freq !== 32'd0 || freq_valid !== 1'b0 || busy !== 1'b0 ||
                timeout_err !== 1'b0 || overrun_cnt !== 16'd0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: start=%b bf=%0d a=%0d k=%0d freq=%h fv=%b busy=%b err=%b ovr=%0d, required all reset values",
                         i, ifc.calc_start, ifc.calc_b_field, ifc.calc_a, ifc.calc_k, freq,
                         freq_valid, busy, timeout_err, overrun_cnt);
            end
        end
        checks++;
        if (ifc.calc_a !== 32'd937546000) begin
            errors++;
            $display("FAIL reset_calc_a: got %0d, required 937546000", ifc.calc_a);
        end
        checks++;
        if (ifc.calc_k !== 8'd1) begin
            errors++;
            $display("FAIL reset_calc_k: got %0d, required 1", ifc.calc_k);
        end
    endtask

    task automatic test_manual();
        int fv_cnt, fv_idx, st_cnt;
        mock_delay = 10;
        mock_freq  = 32'h12345678;
        manual_req = 1'b1;
        b_field    = 32'd335544;
        cycles(1);
        manual_req = 1'b0;
        checks++;
        if (ifc.calc_start !== 1'b0) begin
            errors++;
            $display("FAIL manual_start_t1: got %b, required 0", ifc.calc_start);
        end
        cycles(1);
        checks++;
        if (ifc.calc_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL manual_start_t2: start=%b busy=%b, required 1 1", ifc.calc_start, busy);
        end
        b_field = 32'd1;
        fv_cnt = 0; fv_idx = -1; st_cnt = 0;
        for (int i = 1; i <= 14; i++) begin
            cycles(1);
            if (ifc.calc_start) st_cnt++;
            if (freq_valid) begin fv_cnt++; fv_idx = i; end
            if (i == 12) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL manual_busy_after_done: got %b, required 0", busy);
                end
            end
        end
        checks++;
        if (fv_cnt != 1 || fv_idx != 11 || st_cnt != 0) begin
            errors++;
            $display("FAIL manual_pulses: fv_cnt=%0d fv_idx=%0d extra_starts=%0d, required 1 11 0",
                     fv_cnt, fv_idx, st_cnt);
        end
        checks++;
        if (freq !== 32'h12345678 || ifc.calc_b_field !== 32'd335544) begin
            errors++;
            $display("FAIL manual_result: freq=%h bf=%0d, required 12345678 335544",
                     freq, ifc.calc_b_field);
        end
    endtask

    task automatic test_periodic();
        int starts[$];
        mock_delay = 12;
        period = 16'd19;
        enable = 1'b1;
        for (int i = 1; i <= 110; i++) begin
            cycles(1);
            if (ifc.calc_start) starts.push_back(i);
        end
        enable = 1'b0;
        checks++;
        if (starts.size() != 5 || starts[0] != 21) begin
            errors++;
            $display("FAIL periodic_starts: count=%0d first=%0d, required 5 21",
                     starts.size(), (starts.size() > 0) ? starts[0] : -1);
        end
        for (int j = 1; j < starts.size(); j++) begin
            checks++;
            if (starts[j] - starts[j-1] != 20) begin
                errors++;
                $display("FAIL periodic_interval %0d: got %0d, required 20", j,
                         starts[j] - starts[j-1]);
            end
        end
        checks++;
        if (overrun_cnt !== 16'd0) begin
            errors++;
            $display("FAIL periodic_overrun: got %0d, required 0", overrun_cnt);
        end
        cycles(20);
    endtask

    task automatic test_back_to_back();
        int starts[$];
        int ovr[$];
        mock_delay = 12;
        period = 16'd4;
        enable = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            cycles(1);
            if (ifc.calc_start) begin
                starts.push_back(i);
                ovr.push_back(int'(overrun_cnt));
            end
        end
        enable = 1'b0;
        checks++;
        if (starts.size() != 5 || starts[0] != 6 || ovr[0] != 0) begin
            errors++;
            $display("FAIL b2b_first: count=%0d first=%0d ovr=%0d, required 5 6 0",
                     starts.size(), (starts.size() > 0) ? starts[0] : -1,
                     (ovr.size() > 0) ? ovr[0] : -1);
        end
        for (int j = 1; j < starts.size(); j++) begin
            checks++;
            if (starts[j] - starts[j-1] != 15 || ovr[j] - ovr[j-1] != 2) begin
                errors++;
                $display("FAIL b2b_step %0d: interval=%0d ovr_delta=%0d, required 15 2", j,
                         starts[j] - starts[j-1], ovr[j] - ovr[j-1]);
            end
        end
        cycles(30);
    endtask

    task automatic test_coef();
        mock_delay = 10;
        manual_req = 1'b1;
        cycles(1);
        manual_req = 1'b0;
        cycles(1);
        checks++;
        if (ifc.calc_start !== 1'b1) begin
            errors++;
            $display("FAIL coef_launch: start=%b, required 1", ifc.calc_start);
        end
        for (int i = 1; i <= 13; i++) begin
            cycles(1);
            coef_wr = (i == 1);
            coef_a  = (i == 1) ? 32'd1000 : coef_a;
            if (i == 3 || i == 11 || i == 12) begin
                checks++;
                if (ifc.calc_a !== A_DEF) begin
                    errors++;
                    $display("FAIL coef_hold idx %0d: calc_a=%0d, required %0d", i, ifc.calc_a, A_DEF);
                end
            end
            if (i == 13) begin
                checks++;
                if (ifc.calc_a !== 32'd1000 || ifc.calc_b !== B_DEF) begin
                    errors++;
                    $display("FAIL coef_apply: calc_a=%0d calc_b=%0d, required 1000 %0d",
                             ifc.calc_a, ifc.calc_b, B_DEF);
                end
            end
        end
        coef_wr    = 1'b1;
        coef_a     = 32'd2000;
        manual_req = 1'b1;
        cycles(1);
        coef_wr    = 1'b0;
        manual_req = 1'b0;
        cycles(1);
        checks++;
        if (ifc.calc_a !== 32'd2000 || ifc.calc_start !== 1'b0) begin
            errors++;
            $display("FAIL coef_defer_t2: calc_a=%0d start=%b, required 2000 0",
                     ifc.calc_a, ifc.calc_start);
        end
        cycles(1);
        checks++;
        if (ifc.calc_start !== 1'b1) begin
            errors++;
            $display("FAIL coef_defer_t3: start=%b, required 1", ifc.calc_start);
        end
        cycles(15);
    endtask

    task automatic run_timeout(input bit clear_at_timeout, input string tag);
        int fv_cnt;
        mock_delay = 0;
        mock_freq  = 32'hDEADBEEF;
        manual_req = 1'b1;
        cycles(1);
        manual_req = 1'b0;
        cycles(1);
        fv_cnt = 0;
        for (int i = 1; i <= 66; i++) begin
            clear_err = clear_at_timeout && (i == 64);
            cycles(1);
            if (freq_valid) fv_cnt++;
            if (i == 64) begin
                checks++;
                if (busy !== 1'b1 || timeout_err !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_last_wait: busy=%b err=%b, required 1 0", tag, busy, timeout_err);
                end
            end
            if (i == 65) begin
                checks++;
                if (busy !== 1'b0 || timeout_err !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_expired: busy=%b err=%b, required 0 1", tag, busy, timeout_err);
                end
            end
        end
        clear_err = 1'b0;
        checks++;
        if (fv_cnt != 0 || freq !== 32'h12345678) begin
            errors++;
            $display("FAIL %s_result: fv_cnt=%0d freq=%h, required 0 12345678", tag, fv_cnt, freq);
        end
        clear_err = 1'b1;
        cycles(1);
        clear_err = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL %s_clear: err=%b, required 0", tag, timeout_err);
        end
    endtask

    task automatic test_timeout();
        run_timeout(1'b0, "timeout");
        run_timeout(1'b1, "timeout_vs_clear");
        mock_freq = 32'h12345678;
    endtask

    task automatic test_reset_abort();
        int fv_cnt;
        mock_delay = 10;
        mock_freq  = 32'hCAFEF00D;
        manual_req = 1'b1;
        cycles(1);
        manual_req = 1'b0;
        cycles(1);
        fv_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            reset = (i == 5);
            cycles(1);
            if (freq_valid) fv_cnt++;
        end
        reset = 1'b0;
        checks++;
        if (fv_cnt != 0 || freq !== 32'd0 || busy !== 1'b0 || ifc.calc_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: fv_cnt=%0d freq=%h busy=%b start=%b, required 0 0 0 0",
                     fv_cnt, freq, busy, ifc.calc_start);
        end
        checks++;
        if (ifc.calc_a !== A_DEF) begin
            errors++;
            $display("FAIL reset_abort_coef: calc_a=%0d, required %0d", ifc.calc_a, A_DEF);
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_periodic();
        test_back_to_back();
        test_coef();
        test_timeout();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/b_to_f_ctrl.md
# b_to_f_ctrl

Sequencer for the F(B) frequency calculator. It generates periodic or manual calculation triggers and snapshots the live B-field sample. It applies coefficient updates only between calculations, issues a single-cycle start to the calculator, and waits for its ready. It publishes the resulting frequency word with a valid strobe and supervises the calculation with a watchdog. It sits between the B-field acquisition / register interface and the calculator; its output feeds the RF DDS frequency register.

## Interface
- PERIOD_W, 16: width of trigger period register.
- TIMEOUT, 64: watchdog limit in clk cycles while waiting for calculator ready.
- A_DEF, 937546000: reset value of active/shadow a coefficient.
- B_DEF, 867339: reset value of b coefficient.
- C_DEF, 436224: reset value of c coefficient.
- K_DEF, 1: reset value of harmonic number k.

- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  periodic triggering enable.
- period  in  PERIOD_W  tick every period+1 cycles.
- manual_req  in  1  one-shot calculation request (level sampled each cycle).
- b_field  in  32  live field sample.
- coef_a, coef_b, coef_c  in  32 each  new coefficient values.
- coef_k  in  8  new harmonic number.
- coef_wr  in  1  load coef_* into shadow set.
- clear_err  in  1  clears timeout_err.
- calc_ready  in  1  calculator ready (level).
- calc_freq  in  32  calculator result.
- calc_start  out  1  one-cycle start to calculator.
- calc_b_field  out  32  latched B sample.
- calc_a, calc_b, calc_c  out  32 each  active coefficients.
- calc_k  out  8  active harmonic.
- freq  out  32  last good frequency word.
- freq_valid  out  1  one-cycle strobe on freq update.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky watchdog flag.
- overrun_cnt  out  16  saturating count of dropped periodic ticks.

## Operation
- Reset values: calc_start 0, calc_b_field 0, calc_a/b/c/k = A_DEF/B_DEF/C_DEF/K_DEF (shadow set same), freq 0, freq_valid 0, busy 0, timeout_err 0, overrun_cnt 0, state IDLE, all pending flags 0, period counter 0, ready_d 0.
- Period counter: counts only while enable=1, cleared to 0 when enable=0. tick = enable && cnt==period; on tick cnt<=0. period=0 gives a tick every cycle.
- tick sets tick_pend. A tick while tick_pend is already 1 increments overrun_cnt, saturating at 0xFFFF. manual_req sets man_pend; it is not counted.
- coef_wr: shadow <= coef_* and coef_pend<=1, in any state. A later coef_wr overwrites the shadow.
- FSM:
  - IDLE: if coef_pend, active <= shadow, coef_pend<=0, stay IDLE (launch deferred one cycle). Else if tick_pend||man_pend, calc_b_field <= b_field, clear both pends, go LAUNCH.
  - LAUNCH: calc_start=1 (registered, this cycle only), watchdog<=0, go WAIT.
  - WAIT: the rising edge of calc_ready (calc_ready && !ready_d) means freq<=calc_freq, freq_valid<=1, go DONE. Else if watchdog==TIMEOUT-1, timeout_err<=1, go IDLE, freq unchanged. Else watchdog++.
  - DONE: freq_valid=1 this cycle only, go IDLE.
- A pend set in the same cycle IDLE clears pends survives; set has priority over clear.
- clear_err clears timeout_err. If a timeout occurs in the same cycle, set wins.
- Active coefficients never change outside IDLE.

## Timing
- manual_req high in cycle T: man_pend=1 in T+1, LAUNCH (calc_start=1) in T+2, WAIT from T+3.
- The same cycle counts apply to a tick, if there is no coef_pend. A pending coef adds 1 cycle.
- calc_ready rising edge first visible in WAIT cycle W: freq and freq_valid update at end of W. freq_valid is high in W+1 (DONE), and the state is IDLE in W+2.
- A level-high calc_ready already present when WAIT is entered is ignored; only a 0->1 transition completes the calculation.
- Timeout: the last WAIT cycle is the TIMEOUT-th; IDLE follows.
- Reset in any state aborts the calculation at the next edge. calc_start drops and the result is discarded.

## Test plan
- Reset, then idle for 20 cycles -> every output stays at its reset value; calc_a=937546000, calc_k=1.
- Mock calculator raises ready 10 cycles after start with calc_freq=0x12345678; manual_req pulse at T, b_field=335544 -> calc_start pulses only in T+2, calc_b_field=335544, freq=0x12345678, freq_valid single pulse, busy low again after DONE.
- enable=1, period=19, 12-cycle mock -> calc_start every 20 cycles, overrun_cnt stays 0. Then period=4 -> overrun_cnt increments per extra tick, and calculations run back-to-back.
- coef_wr with coef_a=1000 during WAIT -> calc_a unchanged until IDLE, then 1000 one cycle before the next LAUNCH.
- Mock never raises ready -> timeout_err=1 after 64 WAIT cycles, freq keeps its previous value, no freq_valid. clear_err -> timeout_err=0.
- Assert reset in the 5th WAIT cycle, then the mock raises ready -> no freq_valid, freq=0, state IDLE.
